// File: rtl/truth_table_sweeper_pkg.sv
// Types and constants shared by the truth-table sweeper and its settle timer.
// Encodings come from sweeper_defs.vh so other consumers of the header agree.
`include "sweeper_defs.vh"

package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = `SWEEPER_ST_IDLE,
    ST_WAIT   = `SWEEPER_ST_WAIT,
    ST_SAMPLE = `SWEEPER_ST_SAMPLE,
    ST_DONE   = `SWEEPER_ST_DONE
  } state_e;

  localparam logic [7:0] EXPECT_TT_DEFAULT = `SWEEPER_EXPECT_TT_DEFAULT;
  localparam logic [2:0] LAST_VEC          = 3'd7;

endpackage

// File: rtl/sweeper_defs.vh
// Shared constants for the truth-table sweeper: FSM state encodings and the
// default expected truth table (d = ~((a|b)&c), indexed by {a,b,c}).
`ifndef SWEEPER_DEFS_VH
`define SWEEPER_DEFS_VH

`define SWEEPER_ST_IDLE   2'd0
`define SWEEPER_ST_WAIT   2'd1
`define SWEEPER_ST_SAMPLE 2'd2
`define SWEEPER_ST_DONE   2'd3

`define SWEEPER_EXPECT_TT_DEFAULT 8'h57

`endif

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: counts cycles while enabled, flags the last settle cycle.
// Latency: expire is combinational, high in the SETTLE_CYCLES-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: restart on clear, advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 8 {a,b,c} vectors, checks d against EXPECT_TT.
// Latency: done visible 8*(SETTLE_CYCLES+1) edges after start, sampled on the next.
// Backpressure: start ignored while busy. Optional macro STOP_ON_FAIL_EN stops at first miss.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECT_TT     = EXPECT_TT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       d,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_vec
);

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] err_q, err_d;
  logic       fail_valid_q, fail_valid_d;
  logic [2:0] fail_vec_q, fail_vec_d;
  logic       mismatch;
  logic       settle_expire;

  // Settle counter restarts whenever the FSM is outside WAIT.
  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != ST_WAIT),
    .enable(state_q == ST_WAIT),
    .expire(settle_expire)
  );

  // Next-state and result bookkeeping for the sweep.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    mismatch     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_WAIT;
          vec_d        = 3'd0;
          err_d        = 4'd0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'd0;
        end
      end
      ST_WAIT: begin
        if (settle_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        mismatch = (d != EXPECT_TT[vec_q]);
        if (mismatch) begin
          // At most 8 vectors are checked, so 4 bits never wrap.
          err_d = err_q + 4'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (vec_q == LAST_VEC || (STOP_ON_FAIL && mismatch)) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= 3'd0;
      err_q        <= 4'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign {a, b, c}  = vec_q;
  assign busy       = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == 4'd0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default instance plus a SETTLE_CYCLES=1 one.
// Latency is counted as the index of the edge that first captures done=1
// after the edge accepting start.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       d;
  logic       a, b, c, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] fail_vec;

  logic       start1 = 1'b0;
  logic       d1;
  logic       a1, b1, c1, busy1, done1, pass1, fail_valid1;
  logic [3:0] err_count1;
  logic [2:0] fail_vec1;

  // 0: correct function, 1: stuck at 1, 2: stuck at 0
  int d_mode = 0;
  int vec_cnt = 0;
  int miscompares = 0;

  assign d  = (d_mode == 1) ? 1'b1 : (d_mode == 2) ? 1'b0 : ~((a | b) & c);
  assign d1 = ~((a1 | b1) & c1);

  always #5 clk = ~clk;

  truth_table_sweeper dut (
    .clk(clk), .rst(rst), .start(start), .d(d),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .d(d1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .fail_valid(fail_valid1), .fail_vec(fail_vec1)
  );

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits at negedges (index k after the accepting edge) for done; lat = k+1.
  task automatic run_to_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({busy, done, pass, fail_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/done/pass/fv=%b expected 0000", {busy, done, pass, fail_valid});
    end
    vec_cnt++;
    if ({a, b, c, err_count, fail_vec} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_values: got abc=%b err=%0d fvec=%b expected all 0", {a, b, c}, err_count, fail_vec);
    end
    rst = 1'b0;
  endtask

  task automatic test_correct;
    int lat;
    d_mode = 0;
    pulse_start();
    run_to_done(0, lat);
    vec_cnt++;
    if (lat != 25) begin
      miscompares++;
      $display("FAIL correct_latency: got %0d expected 25", lat);
    end
    vec_cnt++;
    if ({pass, busy, fail_valid} !== 3'b100 || err_count !== 4'd0) begin
      miscompares++;
      $display("FAIL correct_result: got pass/busy/fv=%b err=%0d expected 100 err=0", {pass, busy, fail_valid}, err_count);
    end
    vec_cnt++;
    if ({a, b, c} !== 3'd7) begin
      miscompares++;
      $display("FAIL correct_last_vec: got %b expected 111", {a, b, c});
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL correct_done_hold: got done=%b pass=%b expected 1 1", done, pass);
    end
  endtask

  // Restart straight from DONE with d stuck at 1: vectors 3, 5, 7 miss.
  task automatic test_all_ones;
    int lat;
    d_mode = 1;
    pulse_start();
    @(negedge clk);
    vec_cnt++;
    if ({done, busy, pass, fail_valid} !== 4'b0100 || err_count !== 4'd0) begin
      miscompares++;
      $display("FAIL restart_clear: got done/busy/pass/fv=%b err=%0d expected 0100 err=0", {done, busy, pass, fail_valid}, err_count);
    end
    run_to_done(1, lat);
`ifdef STOP_ON_FAIL_EN
    vec_cnt++;
    if (lat != 13 || err_count !== 4'd1 || {a, b, c} !== 3'd3) begin
      miscompares++;
      $display("FAIL ones_stop: got lat=%0d err=%0d abc=%b expected 13 1 011", lat, err_count, {a, b, c});
    end
`else
    vec_cnt++;
    if (lat != 25 || err_count !== 4'd3) begin
      miscompares++;
      $display("FAIL ones_err: got lat=%0d err=%0d expected 25 3", lat, err_count);
    end
`endif
    vec_cnt++;
    if (fail_vec !== 3'b011 || fail_valid !== 1'b1 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL ones_fail_info: got fvec=%b fv=%b pass=%b expected 011 1 0", fail_vec, fail_valid, pass);
    end
  endtask

  // d stuck at 0: vectors 0,1,2,4,6 miss; first failure is vector 0.
  task automatic test_zeros;
    int lat;
    d_mode = 2;
    pulse_start();
    run_to_done(0, lat);
`ifdef STOP_ON_FAIL_EN
    vec_cnt++;
    if (lat != 4 || err_count !== 4'd1 || {a, b, c} !== 3'd0) begin
      miscompares++;
      $display("FAIL zeros_stop: got lat=%0d err=%0d abc=%b expected 4 1 000", lat, err_count, {a, b, c});
    end
`else
    vec_cnt++;
    if (lat != 25 || err_count !== 4'd5) begin
      miscompares++;
      $display("FAIL zeros_err: got lat=%0d err=%0d expected 25 5", lat, err_count);
    end
`endif
    vec_cnt++;
    if (fail_vec !== 3'b000 || fail_valid !== 1'b1 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL zeros_fail_info: got fvec=%b fv=%b pass=%b expected 000 1 0", fail_vec, fail_valid, pass);
    end
  endtask

  // Extra start pulses captured at edges 3 and 10 of a sweep must be ignored.
  task automatic test_start_while_busy;
    int lat;
    d_mode = 0;
    pulse_start();
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k + 1;
        break;
      end
      start = (k == 2 || k == 9) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    vec_cnt++;
    if (lat != 25 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start: got lat=%0d pass=%b expected 25 1", lat, pass);
    end
  endtask

  // Reset captured at edge 12 of a sweep aborts it without a done pulse.
  task automatic test_reset_mid;
    int lat;
    int done_seen;
    d_mode = 2;
    pulse_start();
    for (int k = 0; k < 12; k++) @(negedge clk);
    vec_cnt++;
    if (err_count === 4'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre_reset: got err=%0d busy=%b expected err>0 busy=1", err_count, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({busy, done, pass, fail_valid, a, b, c, err_count, fail_vec} !== 14'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b done=%b fv=%b abc=%b err=%0d fvec=%b expected all 0",
               busy, done, fail_valid, {a, b, c}, err_count, fail_vec);
    end
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    vec_cnt++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL mid_no_done: got %0d done cycles expected 0", done_seen);
    end
    d_mode = 0;
    pulse_start();
    run_to_done(0, lat);
    vec_cnt++;
    if (lat != 25 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_resweep: got lat=%0d pass=%b expected 25 1", lat, pass);
    end
  endtask

  // SETTLE_CYCLES=1: each vector held 2 cycles, done captured at edge 17.
  task automatic test_settle1;
    int lat;
    logic [2:0] ev;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        lat = k + 1;
        break;
      end
      if (k < 16) begin
        ev = 3'(k / 2);
        vec_cnt++;
        if ({a1, b1, c1} !== ev || busy1 !== 1'b1) begin
          miscompares++;
          $display("FAIL settle1_vec_%0d: got abc=%b busy=%b expected %b 1", k, {a1, b1, c1}, busy1, ev);
        end
      end
    end
    vec_cnt++;
    if (lat != 17 || pass1 !== 1'b1 || err_count1 !== 4'd0) begin
      miscompares++;
      $display("FAIL settle1_done: got lat=%0d pass=%b err=%0d expected 17 1 0", lat, pass1, err_count1);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_all_ones();
    test_zeros();
    test_start_while_busy();
    test_reset_mid();
    test_settle1();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
